ln_rr_merge: RTL and testbench

- N-channel successor to the point-to-point link target pairing.
- Merges NCH independent req/ack link sources onto one outgoing link using round-robin arbitration.
- Every channel uses the 4-phase level handshake with address/data, and peers may run on unrelated clocks.
- Adds per-channel address-range checking, sticky per-channel error flags, a forwarded-transfer counter and optional input synchronisers. It sits between several ln_tgt-style sources and one downstream sink in an hnet fabric.

---
 rtl/ln_rr_merge.sv | 221 ++++++++++++++++++++++
 tb/tb_ln_rr_merge.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ln_rr_merge.sv
// ln_rr_merge: round-robin merge of NCH 4-phase req/ack sources onto one outgoing link,
// with per-channel address-range checking, sticky error flags and a forwarded-word counter.
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 8
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 8
`endif

module ln_rr_merge #(
    parameter int          NCH      = 3,
    parameter int          ASZ      = `ADDRESS_SIZE,
    parameter int          DSZ      = `DATA_SIZE,
    parameter int unsigned MIN_ADDR = 0,
    parameter int unsigned MAX_ADDR = 1,
    parameter int          SYNC     = 2,
    parameter int          CNT_W    = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NCH*ASZ-1:0] i_addr,
    input  logic [NCH*DSZ-1:0] i_dat,
    input  logic [NCH-1:0]     i_req,
    output logic [NCH-1:0]     o_ack,
    output logic [ASZ-1:0]     o_addr,
    output logic [DSZ-1:0]     o_dat,
    output logic               o_req,
    input  logic               i_ack,
    output logic [NCH-1:0]     o_err_vec,
    output logic               o_err,
    output logic [CNT_W-1:0]   o_cnt
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [ASZ-1:0] LO_ADDR = ASZ'(MIN_ADDR);
    localparam logic [ASZ-1:0] HI_ADDR = ASZ'(MAX_ADDR);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAPT = 2'd1,
        ST_OREQ = 2'd2,
        ST_OREL = 2'd3
    } state_t;

    function automatic logic in_range(input logic [ASZ-1:0] a,
                                      input logic [ASZ-1:0] lo,
                                      input logic [ASZ-1:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

    // Bit IW flags a hit; the lowest rotating offset from last wins.
    function automatic logic [IW:0] rr_pick(input logic [NCH-1:0] req,
                                            input logic [IW-1:0]  last);
        logic [IW:0] pick;
        int          c;
        pick = {1'b0, last};
        for (int off = NCH; off >= 1; off--) begin
            c    = int'(last) + off;
            c    = (c >= NCH) ? (c - NCH) : c;
            pick = req[c] ? {1'b1, IW'(c)} : pick;
        end
        return pick;
    endfunction

    function automatic logic [NCH-1:0] onehot(input logic [IW-1:0] idx);
        logic [NCH-1:0] v;
        for (int k = 0; k < NCH; k++) begin
            v[k] = (IW'(k) == idx);
        end
        return v;
    endfunction

    state_t             state_r, state_s;
    logic [IW-1:0]      last_r, last_s;
    logic [NCH-1:0]     ack_r, ack_s;
    logic               req_r, req_s;
    logic [ASZ-1:0]     addr_r, addr_s;
    logic [DSZ-1:0]     dat_r, dat_s;
    logic [NCH-1:0]     err_r, err_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;

    logic [NCH-1:0]     sreq_s;
    logic               sack_s;
    logic [IW:0]        pick_s;
    logic [ASZ-1:0]     sel_addr_s;
    logic [DSZ-1:0]     sel_dat_s;
    logic               own_req_s;

    generate
        if (SYNC == 0) begin : g_nosync
            assign sreq_s = i_req;
            assign sack_s = i_ack;
        end else begin : g_sync
            logic [NCH-1:0] req_m_r, req_q_r;
            logic           ack_m_r, ack_q_r;

            // Two-flop synchronisers for the asynchronous peers' handshake levels.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    req_m_r <= '0;
                    req_q_r <= '0;
                    ack_m_r <= 1'b0;
                    ack_q_r <= 1'b0;
                end else begin
                    req_m_r <= i_req;
                    req_q_r <= req_m_r;
                    ack_m_r <= i_ack;
                    ack_q_r <= ack_m_r;
                end
            end

            assign sreq_s = req_q_r;
            assign sack_s = ack_q_r;
        end
    endgenerate

    assign pick_s    = rr_pick(sreq_s, last_r);
    assign own_req_s = |(sreq_s & onehot(last_r));

    // Mux the word of the channel the arbiter would grant this cycle.
    always_comb begin
        sel_addr_s = '0;
        sel_dat_s  = '0;
        for (int k = 0; k < NCH; k++) begin
            sel_addr_s = (IW'(k) == pick_s[IW-1:0]) ? i_addr[k*ASZ +: ASZ] : sel_addr_s;
            sel_dat_s  = (IW'(k) == pick_s[IW-1:0]) ? i_dat[k*DSZ +: DSZ]  : sel_dat_s;
        end
    end

    // Next-state and next-output logic; last_r doubles as the current grant.
    always_comb begin
        state_s = state_r;
        last_s  = last_r;
        ack_s   = ack_r;
        req_s   = req_r;
        addr_s  = addr_r;
        dat_s   = dat_r;
        err_s   = err_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_s[IW]) begin
                    addr_s  = sel_addr_s;
                    dat_s   = sel_dat_s;
                    ack_s   = onehot(pick_s[IW-1:0]);
                    last_s  = pick_s[IW-1:0];
                    state_s = ST_CAPT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CAPT: begin
                if (!own_req_s) begin
                    ack_s = '0;
                    if (in_range(addr_r, LO_ADDR, HI_ADDR)) begin
                        req_s   = 1'b1;
                        state_s = ST_OREQ;
                    end else begin
                        err_s   = err_r | onehot(last_r);
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_CAPT;
                end
            end
            ST_OREQ: begin
                if (sack_s) begin
                    req_s   = 1'b0;
                    state_s = ST_OREL;
                end else begin
                    state_s = ST_OREQ;
                end
            end
            ST_OREL: begin
                if (!sack_s) begin
                    cnt_s   = cnt_r + CNT_W'(1'b1);
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_OREL;
                end
            end
            default: begin
                ack_s   = '0;
                req_s   = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops the in-flight word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
            last_r  <= IW'(NCH - 1);
            ack_r   <= '0;
            req_r   <= 1'b0;
            addr_r  <= '0;
            dat_r   <= '0;
            err_r   <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            last_r  <= last_s;
            ack_r   <= ack_s;
            req_r   <= req_s;
            addr_r  <= addr_s;
            dat_r   <= dat_s;
            err_r   <= err_s;
            cnt_r   <= cnt_s;
        end
    end

    assign o_ack     = ack_r;
    assign o_req     = req_r;
    assign o_addr    = addr_r;
    assign o_dat     = dat_r;
    assign o_err_vec = err_r;
    assign o_err     = |err_r;
    assign o_cnt     = cnt_r;

endmodule

// File: tb/tb_ln_rr_merge.sv
// Bench for ln_rr_merge: random source/sink agents checked every cycle against a
// transaction-level model, plus directed literal checks and a SYNC=2 latency instance.
module tb_ln_rr_merge;
    localparam int NCH = 3, ASZ = 8, DSZ = 8, CNT_W = 8, WW = ASZ + DSZ;
    localparam int MIN_A = 0, MAX_A = 1;

    logic clk, rst_n;
    logic [NCH*ASZ-1:0] a_addr, b_addr;
    logic [NCH*DSZ-1:0] a_dat, b_dat;
    logic [NCH-1:0] a_req, b_req, a_ack, b_ack, a_errv, b_errv;
    logic [ASZ-1:0] a_oaddr, b_oaddr;
    logic [DSZ-1:0] a_odat, b_odat;
    logic a_oreq, b_oreq, a_iack, b_iack, a_err, b_err;
    logic [CNT_W-1:0] a_cnt, b_cnt;

    ln_rr_merge #(.NCH(NCH), .ASZ(ASZ), .DSZ(DSZ), .MIN_ADDR(MIN_A), .MAX_ADDR(MAX_A),
                  .SYNC(0), .CNT_W(CNT_W)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_addr(a_addr), .i_dat(a_dat), .i_req(a_req),
        .o_ack(a_ack), .o_addr(a_oaddr), .o_dat(a_odat), .o_req(a_oreq), .i_ack(a_iack),
        .o_err_vec(a_errv), .o_err(a_err), .o_cnt(a_cnt));

    ln_rr_merge #(.NCH(NCH), .ASZ(ASZ), .DSZ(DSZ), .MIN_ADDR(MIN_A), .MAX_ADDR(MAX_A),
                  .SYNC(2), .CNT_W(CNT_W)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_addr(b_addr), .i_dat(b_dat), .i_req(b_req),
        .o_ack(b_ack), .o_addr(b_oaddr), .o_dat(b_odat), .o_req(b_oreq), .i_ack(b_iack),
        .o_err_vec(b_errv), .o_err(b_err), .o_cnt(b_cnt));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0, n_fail = 0;

    // Source agents, sink agent and the transaction-level model.
    logic [ASZ-1:0] s_addr [NCH];
    logic [DSZ-1:0] s_dat [NCH];
    int             s_st [NCH];
    logic [WW-1:0]  s_q [NCH][$];
    int             last_m, owner;
    logic [NCH-1:0] err_m, req_prev, ack_prev;
    logic [CNT_W-1:0] cnt_m;
    bit             cnt_due, oreq_m, oreq_clr, free_prev, rand_en, oreq_prev;
    logic [ASZ-1:0] cur_addr;
    logic [DSZ-1:0] cur_dat;
    int             glog[$];
    logic [WW-1:0]  flog[$];
    int             sink_st, sink_cnt, sink_wait;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_next(input int last, input logic [NCH-1:0] r);
        for (int off = 1; off <= NCH; off++) begin
            if (r[(last + off) % NCH]) return (last + off) % NCH;
        end
        return -1;
    endfunction

    function automatic bit link_idle();
        bit busy = 1'b0;
        for (int k = 0; k < NCH; k++) busy |= (s_q[k].size() != 0) || (s_st[k] != 0);
        return !busy && owner < 0 && !oreq_m && sink_st == 0 && !cnt_due;
    endfunction

    task automatic model_reset();
        owner = -1; last_m = NCH - 1; err_m = '0; cnt_m = '0;
        cnt_due = 1'b0; oreq_m = 1'b0; oreq_clr = 1'b0; free_prev = 1'b1; oreq_prev = 1'b0;
        cur_addr = '0; cur_dat = '0;
        for (int k = 0; k < NCH; k++) begin
            s_st[k] = 0; s_q[k].delete(); s_addr[k] = '0; s_dat[k] = '0;
        end
        a_req = '0; a_addr = '0; a_dat = '0; a_iack = 1'b0;
        sink_st = 0; sink_cnt = 0; sink_wait = 0;
        req_prev = '0; ack_prev = '0;
    endtask

    task automatic tick();
        logic [NCH-1:0] rise, fall;
        logic [WW-1:0]  w;
        int             g;
        @(negedge clk);
        rise = a_ack & ~ack_prev;
        fall = ack_prev & ~a_ack;
        if (oreq_clr) begin oreq_m = 1'b0; oreq_clr = 1'b0; end
        if (cnt_due) begin cnt_m = cnt_m + 8'd1; cnt_due = 1'b0; owner = -1; end
        if (rise != '0) begin
            g = rr_next(last_m, req_prev);
            chk("grant_while_busy", 64'(free_prev), 64'd1);
            chk("grant_channel", 64'(rise), 64'(1 << g));
            if (g >= 0) begin
                glog.push_back(g); last_m = g; owner = g;
                cur_addr = s_addr[g]; cur_dat = s_dat[g];
            end
        end else begin
            chk("grant_missing", 64'(free_prev && (req_prev != '0)), 64'd0);
        end
        if (fall != '0) begin
            if (owner >= 0) begin
                chk("ack_release", 64'(fall), 64'(1 << owner));
                chk("ack_early_drop", 64'(s_st[owner]), 64'd2);
                if (int'(cur_addr) >= MIN_A && int'(cur_addr) <= MAX_A) begin
                    oreq_m = 1'b1;
                end else begin
                    err_m[owner] = 1'b1; owner = -1;
                end
            end else begin
                chk("ack_release_unowned", 64'(fall), 64'd0);
            end
        end
        if (a_oreq && !oreq_prev) flog.push_back({a_oaddr, a_odat});
        chk("ack_onehot", 64'($onehot0(a_ack)), 64'd1);
        chk("ack_req_overlap", 64'((a_ack != '0) && a_oreq), 64'd0);
        chk("o_req", 64'(a_oreq), 64'(oreq_m));
        chk("o_addr", 64'(a_oaddr), 64'(cur_addr));
        chk("o_dat", 64'(a_odat), 64'(cur_dat));
        chk("o_err_vec", 64'(a_errv), 64'(err_m));
        chk("o_err", 64'(a_err), 64'(err_m != '0));
        chk("o_cnt", 64'(a_cnt), 64'(cnt_m));
        free_prev = (owner < 0);
        // agents react to what they just saw
        for (int k = 0; k < NCH; k++) begin
            if (rand_en && s_q[k].size() == 0 && s_st[k] == 0 && $urandom_range(0, 3) == 0) begin
                w[WW-1:DSZ] = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(2, 255))
                                                          : 8'($urandom_range(0, 1));
                w[DSZ-1:0]  = 8'($urandom_range(0, 255));
                s_q[k].push_back(w);
            end
            if (s_st[k] == 1 && a_ack[k]) begin
                a_req[k] = 1'b0; s_st[k] = 2;
            end else if (s_st[k] == 2 && !a_ack[k]) begin
                s_st[k] = 0;
            end
            if (s_st[k] == 0 && s_q[k].size() > 0) begin
                w = s_q[k].pop_front();
                s_addr[k] = w[WW-1:DSZ]; s_dat[k] = w[DSZ-1:0];
                a_req[k] = 1'b1; s_st[k] = 1;
            end
            a_addr[k*ASZ +: ASZ] = s_addr[k];
            a_dat[k*DSZ +: DSZ]  = s_dat[k];
        end
        if (sink_st == 0) begin
            if (a_oreq) begin
                if (sink_cnt >= sink_wait) begin
                    a_iack = 1'b1; oreq_clr = 1'b1; sink_st = 1;
                end else begin
                    sink_cnt++;
                end
            end
        end else if (!a_oreq) begin
            a_iack = 1'b0; cnt_due = 1'b1; sink_st = 0; sink_cnt = 0;
            sink_wait = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 12) : $urandom_range(0, 2);
        end
        req_prev = a_req; ack_prev = a_ack; oreq_prev = a_oreq;
    endtask

    int exp_rr[6] = '{1, 2, 0, 1, 2, 0};
    int lat, base;

    initial begin
        rst_n = 1'b0; rand_en = 1'b0;
        b_req = '0; b_iack = 1'b0; b_addr = '0; b_dat = '0;
        model_reset();
        #12;
        chk("rst_ack", 64'(a_ack), 64'd0);
        chk("rst_req", 64'(a_oreq), 64'd0);
        chk("rst_addr_dat", 64'({a_oaddr, a_odat}), 64'd0);
        chk("rst_err_cnt", 64'({a_errv, a_cnt}), 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // SYNC=2 instance: spurious ack ignored, then 3-cycle grant latency
        b_iack = 1'b1;
        tick();
        b_iack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("b_spurious_ack", 64'({b_oreq, b_ack, b_cnt}), 64'd0);
        end
        b_addr[ASZ +: ASZ] = 8'd1; b_dat[DSZ +: DSZ] = 8'h3C; b_req[1] = 1'b1;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            tick(); lat++;
            if (b_ack[1]) break;
        end
        chk("b_sync_latency", 64'(lat), 64'd3);
        b_req[1] = 1'b0;
        for (int i = 0; i < 20 && !b_oreq; i++) tick();
        chk("b_oreq", 64'({b_oreq, b_ack}), 64'({1'b1, 3'b000}));
        chk("b_word", 64'({b_oaddr, b_odat}), 64'h013C);
        b_iack = 1'b1;
        for (int i = 0; i < 20 && b_oreq; i++) tick();
        b_iack = 1'b0;
        for (int i = 0; i < 20 && b_cnt != 8'd1; i++) tick();
        chk("b_cnt", 64'(b_cnt), 64'd1);

        // single forward from channel 0
        s_q[0].push_back({8'd1, 8'hA5});
        tick();
        tick();
        chk("single_ack_latency", 64'(a_ack), 64'b001);
        for (int i = 0; i < 60 && a_cnt != 8'd1; i++) tick();
        chk("single_cnt", 64'(a_cnt), 64'd1);
        chk("single_fwd", 64'(flog.size() > 0 ? flog[0] : 16'h0), 64'h01A5);
        chk("single_err", 64'(a_err), 64'd0);

        // all channels held busy: rotation continues from channel 0's grant
        glog.delete();
        for (int k = 0; k < NCH; k++) begin
            s_q[k].push_back({8'd1, 8'(8'h10 + k)});
            s_q[k].push_back({8'd1, 8'(8'h20 + k)});
        end
        for (int i = 0; i < 400 && a_cnt != 8'd7; i++) tick();
        chk("rr_cnt", 64'(a_cnt), 64'd7);
        chk("rr_len", 64'(glog.size()), 64'd6);
        for (int i = 0; i < 6; i++) chk("rr_order", 64'(glog.size() > i ? glog[i] : -1), 64'(exp_rr[i]));

        // out-of-range word is acked but dropped
        s_q[2].push_back({8'd3, 8'h77});
        for (int i = 0; i < 60 && a_errv == '0; i++) tick();
        chk("range_errv", 64'(a_errv), 64'b100);
        chk("range_err", 64'(a_err), 64'd1);
        chk("range_cnt", 64'(a_cnt), 64'd7);
        s_q[1].push_back({8'd1, 8'h55});
        for (int i = 0; i < 60 && a_cnt != 8'd8; i++) tick();
        chk("range_next_cnt", 64'(a_cnt), 64'd8);
        chk("range_next_errv", 64'(a_errv), 64'b100);

        // slow sink: others wait, then served in rotation order
        sink_wait = 20;
        s_q[0].push_back({8'd1, 8'hC3});
        for (int i = 0; i < 60 && !a_oreq; i++) tick();
        s_q[1].push_back({8'd0, 8'h11});
        s_q[2].push_back({8'd1, 8'h22});
        repeat (15) tick();
        chk("slow_hold", 64'({a_oreq, a_ack, a_oaddr, a_odat}), 64'({1'b1, 3'b000, 8'd1, 8'hC3}));
        for (int i = 0; i < 400 && a_cnt != 8'd11; i++) tick();
        chk("slow_cnt", 64'(a_cnt), 64'd11);
        base = glog.size() - 3;
        for (int i = 0; i < 3; i++) chk("slow_order", 64'(base >= 0 ? glog[base + i] : -1), 64'(i));

        // randomized traffic, then drain
        rand_en = 1'b1;
        repeat (4000) tick();
        rand_en = 1'b0;
        for (int i = 0; i < 2000 && !link_idle(); i++) tick();
        chk("drain", 64'(link_idle()), 64'd1);

        // asynchronous reset while a word is on the outgoing link
        s_q[0].push_back({8'd1, 8'h99});
        for (int i = 0; i < 60 && !a_oreq; i++) tick();
        chk("pre_reset_oreq", 64'(a_oreq), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req_ack", 64'({a_oreq, a_ack}), 64'd0);
        chk("arst_cnt", 64'(a_cnt), 64'd0);
        chk("arst_errv", 64'(a_errv), 64'd0);
        model_reset();
        tick();
        tick();
        #1 rst_n = 1'b1;
        for (int k = 0; k < NCH; k++) s_q[k].push_back({8'd1, 8'(8'h40 + k)});
        tick();
        tick();
        chk("arst_first_grant", 64'(a_ack), 64'b001);
        repeat (30) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
